// File: rtl/sseg_capture.sv
// Seven-segment bus receiver: debounces each multiplexed digit slot, decodes the
// active-low glyph back to a nibble and assembles four digits into one word.
module sseg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  digit_err,
  output logic        frame_err
);

  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0]  seg_q, seg_p;
  logic [3:0]  an_q, an_p;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  seen_reg, seen_next;
  logic [15:0] shadow_reg, shadow_next;
  logic [3:0]  shadow_err_reg, shadow_err_next;
  logic [15:0] value_next;
  logic [3:0]  digit_err_next;
  logic        valid_next, frame_err_next;
  logic        stable, sample_event, sample;
  logic [3:0]  sel;
  logic [4:0]  glyph;

  // {err, nibble}; seg[6]=g ... seg[0]=a, active-low
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0011000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  // sel is one-hot only when exactly one anode is driven low
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sel
      assign sel[gi] = (an_q == ~(4'b0001 << gi));
    end
  endgenerate

  assign stable = ({seg_q, an_q} == {seg_p, an_p});
  // fires only on the cycle the counter is about to reach the threshold
  assign sample_event = stable && (cnt_reg == STABLE_LAST);
  assign sample       = sample_event && (|sel);
  assign glyph        = decode(seg_q);

  always_comb begin
    cnt_next = 8'd1;
    if (stable) cnt_next = (cnt_reg == STABLE_MAX) ? cnt_reg : cnt_reg + 8'd1;
  end

  always_comb begin
    seen_next       = seen_reg;
    shadow_next     = shadow_reg;
    shadow_err_next = shadow_err_reg;
    value_next      = value;
    digit_err_next  = digit_err;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;
    if (sample) begin
      if (|(seen_reg & sel)) begin
        frame_err_next = 1'b1;
        seen_next      = sel;
      end else begin
        seen_next = seen_reg | sel;
      end
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          shadow_next[4*i +: 4] = glyph[3:0];
          shadow_err_next[i]    = glyph[4];
        end
      end
      if (seen_next == 4'hF) begin
        value_next     = shadow_next;
        digit_err_next = shadow_err_next;
        valid_next     = 1'b1;
        seen_next      = 4'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q          <= 7'h7F;
      an_q           <= 4'hF;
      seg_p          <= 7'h7F;
      an_p           <= 4'hF;
      cnt_reg        <= 8'd0;
      seen_reg       <= 4'h0;
      shadow_reg     <= 16'h0000;
      shadow_err_reg <= 4'h0;
      value          <= 16'h0000;
      digit_err      <= 4'h0;
      valid          <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      seg_q          <= seg;
      an_q           <= an;
      seg_p          <= seg_q;
      an_p           <= an_q;
      cnt_reg        <= cnt_next;
      seen_reg       <= seen_next;
      shadow_reg     <= shadow_next;
      shadow_err_reg <= shadow_err_next;
      value          <= value_next;
      digit_err      <= digit_err_next;
      valid          <= valid_next;
      frame_err      <= frame_err_next;
    end
  end

endmodule
